axis_slave: RTL

- Receive end of the resizer's stream path: accepts AXI-Stream beats on the slave port and packs each beat into one input-buffer entry.
- The per-lane {keep, last, data} entry format is the same one the output-side master block consumes.
- A 2-entry skid register decouples the registered s_ready_o from input-buffer backpressure.
- Also drops null beats, flags non-contiguous keep, and tracks packet state and the completed-packet count.

---
 rtl/axis_slave.sv | 113 +++++++++++
 1 files changed

// File: rtl/axis_slave.sv
// AXI-Stream receive side of the resizer: packs each accepted beat into one
// input-buffer entry and pushes it through a 2-entry skid register.
module axis_slave #(
  parameter int S_KEEP_WIDTH    = 2,
  parameter int T_DATA_WIDTH    = 1,
  parameter int BUF_IN_ENTRY_SZ = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH,
  parameter int PKT_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic                       s_last_i,
  input  logic [S_KEEP_WIDTH-1:0]    s_keep_i,
  input  logic [T_DATA_WIDTH-1:0]    s_data_i [S_KEEP_WIDTH],
  input  logic                       overflow,
  output logic                       slave_entry_valid,
  output logic [BUF_IN_ENTRY_SZ-1:0] slave_entry,
  output logic                       keep_err_o,
  output logic                       in_packet_o,
  output logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_o
);

  localparam int LANE_W = T_DATA_WIDTH + 2;

  logic [BUF_IN_ENTRY_SZ-1:0] skidMem_q [2];
  logic [1:0]                 occ_q, occ_d;
  logic                       head_q;
  logic                       ready_q;
  logic                       keepErr_q;
  logic                       inPacket_q;
  logic [PKT_CNT_WIDTH-1:0]   pktCnt_q;

  logic                       accept, isNull, store, pop;
  logic                       tailIdx;
  logic                       keepBad;
  logic                       popHasLast;
  logic [S_KEEP_WIDTH-1:0]    keepInc;
  logic [BUF_IN_ENTRY_SZ-1:0] packedEntry;
  logic [BUF_IN_ENTRY_SZ-1:0] headEntry;
  int                         topLane;

  assign accept  = s_valid_i & ready_q;
  assign isNull  = (s_keep_i == '0) & ~s_last_i;
  assign store   = accept & ~isNull;
  assign pop     = (occ_q != 2'd0) & ~overflow;
  assign tailIdx = head_q ^ occ_q[0];
  assign occ_d   = occ_q + {1'b0, store} - {1'b0, pop};

  // Legal keep is a run of ones starting at lane 0, so keep+1 shares no bits with it.
  assign keepInc = s_keep_i + S_KEEP_WIDTH'(1);
  assign keepBad = (s_keep_i != '0) && ((s_keep_i & keepInc) != '0);

  always_comb begin
    packedEntry = '0;
    topLane     = 0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (s_keep_i[i]) topLane = i;
    end
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (s_keep_i[i]) begin
        packedEntry[i*LANE_W +: LANE_W] = {1'b1, s_last_i && (i == topLane), s_data_i[i]};
      end
    end
    // A keep-less closing beat still has to carry its last marker somewhere.
    if (s_keep_i == '0) packedEntry[T_DATA_WIDTH] = s_last_i;
  end

  assign headEntry = skidMem_q[head_q];

  always_comb begin
    popHasLast = 1'b0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      popHasLast = popHasLast | headEntry[i*LANE_W + T_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidMem_q[0] <= '0;
      skidMem_q[1] <= '0;
      occ_q        <= 2'd0;
      head_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      if (store) skidMem_q[tailIdx] <= packedEntry;
      if (pop) head_q <= ~head_q;
      occ_q   <= occ_d;
      ready_q <= (occ_d <= 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keepErr_q  <= 1'b0;
      inPacket_q <= 1'b0;
      pktCnt_q   <= '0;
    end else begin
      if (accept && keepBad) keepErr_q <= 1'b1;
      if (accept && s_last_i) inPacket_q <= 1'b0;
      else if (store) inPacket_q <= 1'b1;
      if (pop && popHasLast) pktCnt_q <= pktCnt_q + PKT_CNT_WIDTH'(1);
    end
  end

  assign s_ready_o         = ready_q;
  assign slave_entry_valid = pop;
  assign slave_entry       = headEntry;
  assign keep_err_o        = keepErr_q;
  assign in_packet_o       = inPacket_q;
  assign pkt_cnt_o         = pktCnt_q;

endmodule
